// File: rtl/ucom_timer_pkg.sv
// Shared constants and helpers for the uCOM-4x multi-channel interval timer.
package ucom_timer_pkg;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

    localparam int DEF_PRE_W = 6;
    localparam int DEF_CNT_W = 6;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ucom_timer_if.sv
// Core-side command/status bundle of the interval timer.
interface ucom_timer_if
    import ucom_timer_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int CNT_W    = DEF_CNT_W
);
    localparam int CH_W = ch_w(CHANNELS);

    logic                ce;
    logic                ld;
    logic [CH_W-1:0]     ld_ch;
    logic [CNT_W-1:0]    ld_val;
    logic                ld_mode;
    logic                clr;
    logic [CH_W-1:0]     clr_ch;
    logic                ien_we;
    logic [CHANNELS-1:0] ien_val;
    logic [CH_W-1:0]     rd_ch;
    logic [CNT_W-1:0]    rd_cnt;
    logic [CHANNELS-1:0] run;
    logic [CHANNELS-1:0] tm;
    logic [CHANNELS-1:0] ovf;
    logic                irq;

    modport master (
        output ce, ld, ld_ch, ld_val, ld_mode,
        output clr, clr_ch, ien_we, ien_val, rd_ch,
        input  rd_cnt, run, tm, ovf, irq
    );

    modport slave (
        input  ce, ld, ld_ch, ld_val, ld_mode,
        input  clr, clr_ch, ien_we, ien_val, rd_ch,
        output rd_cnt, run, tm, ovf, irq
    );

endinterface

// File: rtl/ucom_timer_chan.sv
// One timer channel: prescaler, down-counter, reload value and flags.
module ucom_timer_chan
    import ucom_timer_pkg::*;
#(
    parameter int PRE_W = DEF_PRE_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             ld,
    input  logic             clr,
    input  logic [CNT_W-1:0] ld_val,
    input  logic             ld_mode,
    output logic [CNT_W-1:0] cnt,
    output logic             run,
    output logic             tm,
    output logic             ovf
);

    logic [PRE_W-1:0] r_pre;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_rld;
    logic             r_mode;
    logic             r_run;
    logic             r_tm;
    logic             r_ovf;

    logic w_tick;
    logic w_wrap;
    logic w_expire;

    assign w_tick   = ce && r_run;
    assign w_wrap   = w_tick && (&r_pre);
    assign w_expire = w_wrap && (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre  <= '0;
            r_cnt  <= '0;
            r_rld  <= '0;
            r_mode <= MODE_ONESHOT;
            r_run  <= 1'b0;
            r_tm   <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (ld) begin
            r_pre  <= '0;
            r_cnt  <= ld_val;
            r_rld  <= ld_val;
            r_mode <= ld_mode;
            r_run  <= 1'b1;
            r_tm   <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_tick)
                r_pre <= r_pre + PRE_W'(1);
            if (w_wrap && !w_expire)
                r_cnt <= r_cnt - CNT_W'(1);
            // a clear in the expiring cycle only suppresses the overrun term
            if (w_expire) begin
                r_tm  <= 1'b1;
                r_ovf <= r_ovf | (r_tm & ~clr);
                if (r_mode == MODE_RELOAD)
                    r_cnt <= r_rld;
                else
                    r_run <= 1'b0;
            end else if (clr) begin
                r_tm  <= 1'b0;
                r_ovf <= 1'b0;
            end
        end
    end

    assign cnt = r_cnt;
    assign run = r_run;
    assign tm  = r_tm;
    assign ovf = r_ovf;

endmodule

// File: rtl/ucom_timer.sv
// Multi-channel interval timer: channel array, command decode, ien/irq, readback.
module ucom_timer
    import ucom_timer_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int PRE_W    = DEF_PRE_W,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         _RESET,
    ucom_timer_if.slave  bus
);

    localparam int CH_W = ch_w(CHANNELS);

    logic [CHANNELS-1:0] w_ld;
    logic [CHANNELS-1:0] w_clr;
    logic [CHANNELS-1:0] w_run;
    logic [CHANNELS-1:0] w_tm;
    logic [CHANNELS-1:0] w_ovf;
    logic [CNT_W-1:0]    w_cnt [CHANNELS];
    logic [CNT_W-1:0]    w_rd_cnt;
    logic [CHANNELS-1:0] r_ien;
    logic                r_irq;

    // channel indices >= CHANNELS never match, so those commands fall away
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign w_ld[g]  = bus.ld  && (bus.ld_ch  == CH_W'(g));
        assign w_clr[g] = bus.clr && (bus.clr_ch == CH_W'(g));

        ucom_timer_chan #(
            .PRE_W (PRE_W),
            .CNT_W (CNT_W)
        ) u_chan (
            .clk     (clk),
            .rst_n   (_RESET),
            .ce      (bus.ce),
            .ld      (w_ld[g]),
            .clr     (w_clr[g]),
            .ld_val  (bus.ld_val),
            .ld_mode (bus.ld_mode),
            .cnt     (w_cnt[g]),
            .run     (w_run[g]),
            .tm      (w_tm[g]),
            .ovf     (w_ovf[g])
        );
    end

    always_comb begin
        w_rd_cnt = '0;
        for (int i = 0; i < CHANNELS; i++)
            if (bus.rd_ch == CH_W'(i))
                w_rd_cnt = w_cnt[i];
    end

    always_ff @(posedge clk or negedge _RESET) begin
        if (!_RESET) begin
            r_ien <= '0;
            r_irq <= 1'b0;
        end else begin
            if (bus.ien_we)
                r_ien <= bus.ien_val;
            r_irq <= |(w_tm & r_ien);
        end
    end

    assign bus.rd_cnt = w_rd_cnt;
    assign bus.run    = w_run;
    assign bus.tm     = w_tm;
    assign bus.ovf    = w_ovf;
    assign bus.irq    = r_irq;

endmodule

// File: tb/tb_ucom_timer.sv
// Bench for ucom_timer: directed PRE_W=6 instance plus model-checked PRE_W=2 instance.
module tb_ucom_timer;
    import ucom_timer_pkg::*;

    localparam int NCH = 3;
    localparam int P2  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ucom_timer_if #(.CHANNELS(NCH), .CNT_W(4)) b2 ();
    ucom_timer_if #(.CHANNELS(2), .CNT_W(6)) b6 ();

    ucom_timer #(.CHANNELS(NCH), .PRE_W(2), .CNT_W(4)) u2 (
        .clk    (clk),
        ._RESET (rst_n),
        .bus    (b2)
    );

    ucom_timer #(.CHANNELS(2), .PRE_W(6), .CNT_W(6)) u6 (
        .clk    (clk),
        ._RESET (rst_n),
        .bus    (b6)
    );

    int npass = 0;
    int nfail = 0;
    int ntot  = 0;

    // behavioural model: ce ticks elapsed since (re)load, expiry at (val+1)*P2
    int m_val [NCH];
    int m_n   [NCH];
    bit m_mode[NCH];
    bit m_run [NCH];
    bit m_tm  [NCH];
    bit m_ovf [NCH];
    bit m_ien [NCH];
    bit m_irq;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_cnt(input int c);
        return m_run[c] ? m_val[c] - m_n[c] / P2 : 0;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_val[c] = 0; m_n[c] = 0; m_mode[c] = 0;
            m_run[c] = 0; m_tm[c] = 0; m_ovf[c] = 0; m_ien[c] = 0;
        end
        m_irq = 0;
    endtask

    task automatic model_step();
        bit irq_n;
        bit ldc, clrc, ex;
        irq_n = 0;
        for (int c = 0; c < NCH; c++)
            irq_n |= m_tm[c] & m_ien[c];
        for (int c = 0; c < NCH; c++) begin
            ldc  = b2.ld  && (int'(b2.ld_ch)  == c);
            clrc = b2.clr && (int'(b2.clr_ch) == c);
            if (ldc) begin
                m_val[c] = int'(b2.ld_val); m_mode[c] = b2.ld_mode;
                m_n[c] = 0; m_run[c] = 1; m_tm[c] = 0; m_ovf[c] = 0;
            end else begin
                ex = 0;
                if (b2.ce && m_run[c]) begin
                    m_n[c]++;
                    if (m_n[c] == (m_val[c] + 1) * P2) ex = 1;
                end
                if (ex) begin
                    m_ovf[c] = m_ovf[c] | (m_tm[c] & !clrc);
                    m_tm[c] = 1;
                    if (m_mode[c]) m_n[c] = 0;
                    else m_run[c] = 0;
                end else if (clrc) begin
                    m_tm[c] = 0; m_ovf[c] = 0;
                end
            end
        end
        if (b2.ien_we)
            for (int c = 0; c < NCH; c++) m_ien[c] = b2.ien_val[c];
        m_irq = irq_n;
    endtask

    task automatic check_u2();
        logic [NCH-1:0] er, et, eo;
        int erd;
        for (int c = 0; c < NCH; c++) begin
            er[c] = m_run[c]; et[c] = m_tm[c]; eo[c] = m_ovf[c];
        end
        erd = (int'(b2.rd_ch) < NCH) ? exp_cnt(int'(b2.rd_ch)) : 0;
        chk("u2.run", 32'(b2.run), 32'(er));
        chk("u2.tm", 32'(b2.tm), 32'(et));
        chk("u2.ovf", 32'(b2.ovf), 32'(eo));
        chk("u2.irq", 32'(b2.irq), 32'(m_irq));
        chk("u2.rd_cnt", 32'(b2.rd_cnt), 32'(erd));
    endtask

    task automatic tick();
        if (rst_n) model_step();
        else model_reset();
        @(posedge clk);
        #1;
        check_u2();
    endtask

    initial begin
        model_reset();
        b2.ce = 0; b2.ld = 0; b2.ld_ch = 0; b2.ld_val = 0; b2.ld_mode = 0;
        b2.clr = 0; b2.clr_ch = 0; b2.ien_we = 0; b2.ien_val = 0; b2.rd_ch = 0;
        b6.ce = 0; b6.ld = 0; b6.ld_ch = 0; b6.ld_val = 0; b6.ld_mode = 0;
        b6.clr = 0; b6.clr_ch = 0; b6.ien_we = 0; b6.ien_val = 0; b6.rd_ch = 0;

        // reset held with ce toggling
        for (int k = 0; k < 6; k++) begin
            b2.ce = k[0]; b6.ce = k[0];
            tick();
            chk("u6.rst_run", 32'(b6.run), 0);
            chk("u6.rst_tm", 32'(b6.tm), 0);
            chk("u6.rst_irq", 32'(b6.irq), 0);
            chk("u6.rst_cnt", 32'(b6.rd_cnt), 0);
        end
        rst_n = 1;

        b2.ce = 1; b6.ce = 1;
        repeat (1000) tick();
        chk("u6.idle_tm", 32'(b6.tm), 0);
        chk("u6.idle_irq", 32'(b6.irq), 0);

        // one-shot, PRE_W=6, val=1 -> 128 ce
        b2.ce = 0;
        b6.ce = 0; b6.ld = 1; b6.ld_ch = 0; b6.ld_val = 1; b6.ld_mode = 0;
        tick();
        b6.ld = 0;
        chk("u6.ld_run", 32'(b6.run[0]), 1);
        chk("u6.ld_cnt", 32'(b6.rd_cnt), 1);
        b6.ce = 1;
        for (int k = 1; k <= 128; k++) begin
            tick();
            if (k == 127) chk("u6.os_tm127", 32'(b6.tm[0]), 0);
            if (k == 128) begin
                chk("u6.os_tm128", 32'(b6.tm[0]), 1);
                chk("u6.os_run", 32'(b6.run[0]), 0);
                chk("u6.os_cnt", 32'(b6.rd_cnt), 0);
            end
        end
        repeat (200) tick();
        chk("u6.hold_tm", 32'(b6.tm[0]), 1);
        chk("u6.hold_run", 32'(b6.run[0]), 0);
        chk("u6.hold_cnt", 32'(b6.rd_cnt), 0);
        chk("u6.hold_ovf", 32'(b6.ovf[0]), 0);
        b6.ce = 0;

        // auto-reload ch1, val=3, PRE_W=2 -> period 16
        b2.ld = 1; b2.ld_ch = 1; b2.ld_val = 3; b2.ld_mode = 1; b2.rd_ch = 1;
        tick();
        b2.ld = 0; b2.ce = 1;
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (k == 15) chk("ar.tm15", 32'(b2.tm[1]), 0);
            if (k == 16) begin
                chk("ar.tm16", 32'(b2.tm[1]), 1);
                chk("ar.reload", 32'(b2.rd_cnt), 3);
                chk("ar.run16", 32'(b2.run[1]), 1);
            end
            if (k == 31) chk("ar.ovf31", 32'(b2.ovf[1]), 0);
            if (k == 32) begin
                chk("ar.ovf32", 32'(b2.ovf[1]), 1);
                chk("ar.run32", 32'(b2.run[1]), 1);
            end
        end

        // interrupt masking and acknowledge
        b2.ce = 0; b2.ien_we = 1; b2.ien_val = 3'b001;
        tick();
        b2.ien_we = 0;
        tick();
        chk("irq.masked", 32'(b2.irq), 0);
        b2.ld = 1; b2.ld_ch = 0; b2.ld_val = 0; b2.ld_mode = 0; b2.rd_ch = 0;
        tick();
        b2.ld = 0; b2.ce = 1;
        repeat (4) tick();
        chk("irq.tm0", 32'(b2.tm[0]), 1);
        chk("irq.lag", 32'(b2.irq), 0);
        b2.ce = 0;
        tick();
        chk("irq.rise", 32'(b2.irq), 1);
        b2.clr = 1; b2.clr_ch = 0;
        tick();
        b2.clr = 0;
        chk("irq.clr_tm", 32'(b2.tm[0]), 0);
        chk("irq.clr_hold", 32'(b2.irq), 1);
        tick();
        chk("irq.fall", 32'(b2.irq), 0);

        // clear on the expiring cycle
        b2.ld = 1; b2.ld_ch = 2; b2.ld_val = 1; b2.ld_mode = 0; b2.rd_ch = 2;
        tick();
        b2.ld = 0; b2.ce = 1;
        for (int k = 1; k <= 8; k++) begin
            if (k == 8) begin b2.clr = 1; b2.clr_ch = 2; end
            tick();
        end
        b2.clr = 0;
        chk("col.clr_tm", 32'(b2.tm[2]), 1);

        // load on the expiring cycle
        b2.ce = 0;
        b2.ld = 1; b2.ld_ch = 2; b2.ld_val = 0; b2.ld_mode = 1;
        tick();
        b2.ld = 0; b2.ce = 1;
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) begin
                b2.ld = 1; b2.ld_ch = 2; b2.ld_val = 5; b2.ld_mode = 1;
            end
            tick();
        end
        b2.ld = 0;
        chk("col.ld_tm", 32'(b2.tm[2]), 0);
        chk("col.ld_cnt", 32'(b2.rd_cnt), 5);
        chk("col.ld_run", 32'(b2.run[2]), 1);

        // load ch0 while ch1 ticks
        b2.rd_ch = 1;
        b2.ld = 1; b2.ld_ch = 0; b2.ld_val = 2; b2.ld_mode = 0;
        tick();
        b2.ld = 0;
        repeat (8) tick();

        // randomized traffic, including out-of-range channel numbers
        for (int k = 0; k < 400; k++) begin
            b2.ce      = ($urandom % 2) == 0;
            b2.ld      = ($urandom % 12) == 0;
            b2.ld_ch   = 2'($urandom % 4);
            b2.ld_val  = 4'($urandom);
            b2.ld_mode = 1'($urandom);
            b2.clr     = ($urandom % 8) == 0;
            b2.clr_ch  = 2'($urandom % 4);
            b2.ien_we  = ($urandom % 16) == 0;
            b2.ien_val = 3'($urandom);
            b2.rd_ch   = 2'($urandom % 4);
            tick();
        end

        // mid-count asynchronous reset
        b2.clr = 0; b2.ien_we = 0; b2.rd_ch = 0;
        b2.ld = 1; b2.ld_ch = 0; b2.ld_val = 7; b2.ld_mode = 1; b2.ce = 1;
        tick();
        b2.ld = 0;
        repeat (10) tick();
        @(posedge clk);
        #3;
        rst_n = 0;
        model_reset();
        #1;
        chk("mrst.run", 32'(b2.run), 0);
        chk("mrst.cnt", 32'(b2.rd_cnt), 0);
        chk("mrst.tm", 32'(b2.tm), 0);
        chk("mrst.u6tm", 32'(b6.tm), 0);
        #9;
        rst_n = 1;
        repeat (100) tick();
        chk("mrst.after_tm", 32'(b2.tm), 0);
        chk("mrst.after_irq", 32'(b2.irq), 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
